// File: rtl/timer_1us_tick_if.sv
// Enable/tick bundle between a pacing timer and the block it strobes.
interface timer_1us_tick_if;
   logic en;
   logic q;

   modport master (output en, input q);
   modport slave  (input en, output q);
endinterface

// File: rtl/timer_1us_tick.sv
// Periodic tick generator: a 1 us prescaler feeding a microsecond counter,
// emitting a one-clock strobe every PERIOD_US microseconds.
module timer_1us_tick #(
   parameter int unsigned PERIOD_US  = 1,
   parameter int unsigned CLK_PER_US = 36
) (
   input  logic             clk_36MHz,
   input  logic             reset,
   timer_1us_tick_if.slave  bus
);

   localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam int unsigned UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

   logic [PW-1:0] presc;
   logic [UW-1:0] us_cnt;
   logic          q_reg;
   logic          presc_term;
   logic          us_term;

   assign presc_term = (presc == PW'(CLK_PER_US - 1));
   assign us_term    = (us_cnt == UW'(PERIOD_US - 1));

   // Counters freeze while disabled so a paused period resumes where it left off.
   always_ff @(posedge clk_36MHz) begin
      if (!reset) begin
         presc  <= '0;
         us_cnt <= '0;
         q_reg  <= 1'b0;
      end else if (!bus.en) begin
         q_reg  <= 1'b0;
      end else begin
         presc <= presc_term ? '0 : presc + PW'(1);
         if (presc_term) begin
            us_cnt <= us_term ? '0 : us_cnt + UW'(1);
         end
         q_reg <= presc_term & us_term;
      end
   end

   assign bus.q = q_reg;

endmodule

// File: tb/tb_timer_1us_tick.sv
// Directed bench for timer_1us_tick across several parameterisations.
module tb_timer_1us_tick;

   logic clk;
   logic rst_a, rst_b, rst_c, rst_d;
   int   n_tests;
   int   n_fail;
   int   ecnt_a;

   timer_1us_tick_if ifa ();
   timer_1us_tick_if ifb ();
   timer_1us_tick_if ifc ();
   timer_1us_tick_if ifd ();

   timer_1us_tick #(.PERIOD_US(3), .CLK_PER_US(4)) u_a (
      .clk_36MHz (clk), .reset (rst_a), .bus (ifa));
   timer_1us_tick #(.PERIOD_US(1), .CLK_PER_US(1)) u_b (
      .clk_36MHz (clk), .reset (rst_b), .bus (ifb));
   timer_1us_tick u_c (
      .clk_36MHz (clk), .reset (rst_c), .bus (ifc));
   timer_1us_tick #(.PERIOD_US(300), .CLK_PER_US(36)) u_d (
      .clk_36MHz (clk), .reset (rst_d), .bus (ifd));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One edge of instance A; expected q from the count of enabled edges since reset.
   task automatic step_a(input logic rst_v, input logic en_v, input string tag);
      int exp;
      @(negedge clk);
      rst_a  = rst_v;
      ifa.en = en_v;
      @(posedge clk);
      #1;
      if (!rst_v) ecnt_a = 0;
      else if (en_v) ecnt_a++;
      exp = (rst_v && en_v && ecnt_a != 0 && (ecnt_a % 12) == 0) ? 1 : 0;
      check_eq($sformatf("%s@%0d", tag, ecnt_a), int'(ifa.q), exp);
   endtask

   task automatic step_b(input logic rst_v, input logic en_v, input int exp, input string tag);
      @(negedge clk);
      rst_b  = rst_v;
      ifb.en = en_v;
      @(posedge clk);
      #1;
      check_eq(tag, int'(ifb.q), exp);
   endtask

   initial begin
      int first_d, pulses_d, last_d;
      n_tests = 0;
      n_fail  = 0;
      ecnt_a  = 0;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
      ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0; ifd.en = 1'b0;

      // A: reset with en low, then reset dominating en high
      step_a(1'b0, 1'b0, "a_rst");
      step_a(1'b0, 1'b0, "a_rst");
      for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, "a_rst_en");

      // A: free run, pulses after enabled edges 12, 24, 36
      for (int i = 0; i < 36; i++) step_a(1'b1, 1'b1, "a_run");

      // A: pause after 7 edges for 5 cycles, period completes after 12 enabled edges
      for (int i = 0; i < 7; i++) step_a(1'b1, 1'b1, "a_pre");
      for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, "a_pause");
      for (int i = 0; i < 17; i++) step_a(1'b1, 1'b1, "a_resume");

      // A: reset on the 10th edge discards the partial period
      for (int i = 0; i < 9; i++) step_a(1'b1, 1'b1, "a_pre_rst");
      step_a(1'b0, 1'b1, "a_mid_rst");
      for (int i = 0; i < 13; i++) step_a(1'b1, 1'b1, "a_post_rst");

      // B: N==1, q high every enabled cycle
      step_b(1'b0, 1'b1, 0, "b_rst");
      step_b(1'b0, 1'b1, 0, "b_rst");
      for (int i = 0; i < 8; i++) step_b(1'b1, 1'b1, 1, "b_run");
      step_b(1'b1, 1'b0, 0, "b_pause");
      step_b(1'b1, 1'b1, 1, "b_resume");
      step_b(1'b0, 1'b1, 0, "b_rst2");

      // C: defaults, N = 36
      @(negedge clk);
      rst_c  = 1'b1;
      ifc.en = 1'b1;
      for (int k = 1; k <= 72; k++) begin
         @(posedge clk);
         #1;
         if (k == 35 || k == 36 || k == 37 || k == 71 || k == 72)
            check_eq($sformatf("c_def@%0d", k), int'(ifc.q), (k % 36 == 0) ? 1 : 0);
      end

      // D: long period, N = 10800; first pulse and exactly one in the next window
      first_d  = 0;
      pulses_d = 0;
      last_d   = 0;
      @(negedge clk);
      rst_d  = 1'b1;
      ifd.en = 1'b1;
      for (int k = 1; k <= 21600; k++) begin
         @(posedge clk);
         #1;
         if (ifd.q) begin
            if (first_d == 0) first_d = k;
            else pulses_d++;
            if (k > 10800) last_d = k;
         end
      end
      check_eq("d_first", first_d, 10800);
      check_eq("d_window", pulses_d, 1);
      check_eq("d_second", last_d, 21600);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
